// File: rtl/meteor_spawn_ctrl.sv
// meteor_spawn_ctrl: frame-rate game FSM with lives/score/level tracking and a round-robin meteor respawn arbiter
// Ports:
//   frame_clk, Reset   frame clock, asynchronous active-high reset
//   start, collide     start key and ship/meteor overlap flag (levels, edge-detected here)
//   slot_req[3:0]      meteor i is off-screen and wants a respawn
//   seed[9:0]          LFSR seed loaded on Reset (0 maps to 10'h2A5)
//   game_state[1:0]    0 IDLE, 1 PLAY, 2 HIT, 3 OVER; freeze is high outside PLAY
//   spawn_grant/_x/_speed  one-frame one-hot grant with its X position and fall speed
//   score, lives, level    game counters
module meteor_spawn_ctrl #(
   parameter int LIVES      = 3,
   parameter int HIT_FRAMES = 60,
   parameter int SPAWN_GAP  = 8,
   parameter int LEVEL_PTS  = 16,
   parameter int X_RANGE    = 556
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic        start,
   input  logic        collide,
   input  logic [3:0]  slot_req,
   input  logic [9:0]  seed,
   output logic [1:0]  game_state,
   output logic        freeze,
   output logic [3:0]  spawn_grant,
   output logic [9:0]  spawn_x,
   output logic [3:0]  spawn_speed,
   output logic [15:0] score,
   output logic [2:0]  lives,
   output logic [2:0]  level
);
   localparam int GW = $clog2(SPAWN_GAP + 1);
   localparam int HW = $clog2(HIT_FRAMES + 1);

   typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} state_t;

   state_t        state, state_n;
   logic [1:0]    ptr, gnt_idx;
   logic [GW-1:0] gap;
   logic [HW-1:0] hit_cnt;
   logic [9:0]    lfsr;
   logic [15:0]   lvl_div;
   logic          start_q, collide_q, start_rise, collide_rise, grant_ok;

   assign start_rise   = start & ~start_q;
   assign collide_rise = collide & ~collide_q;
   assign game_state   = state;
   assign lvl_div      = score / 16'(LEVEL_PTS);
   // a collision in the same frame as a possible grant suppresses the grant
   assign grant_ok     = (state == PLAY) && (gap == '0) && !collide_rise && (|slot_req);

   // scan downward so the lowest offset from the pointer wins
   always_comb begin
      gnt_idx = ptr;
      for (int i = 3; i >= 0; i--)
         if (slot_req[ptr + 2'(i)]) gnt_idx = ptr + 2'(i);
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start_rise) state_n = PLAY;
         PLAY:    if (collide_rise) state_n = HIT;
         HIT:     if (hit_cnt == '0) state_n = (lives == 3'd0) ? OVER : PLAY;
         OVER:    if (start_rise) state_n = IDLE;
         default: state_n = state;
      endcase
   end

   always_ff @(posedge frame_clk or posedge Reset)
      if (Reset) state <= IDLE;
      else state <= state_n;

   always_ff @(posedge frame_clk or posedge Reset)
      if (Reset) begin
         freeze      <= 1'b1;
         spawn_grant <= '0;
         spawn_x     <= '0;
         spawn_speed <= 4'd2;
         score       <= '0;
         lives       <= 3'(LIVES);
         level       <= '0;
         ptr         <= '0;
         gap         <= '0;
         hit_cnt     <= '0;
         lfsr        <= (seed == 10'd0) ? 10'h2A5 : seed;
         start_q     <= 1'b0;
         collide_q   <= 1'b0;
      end else begin
         start_q     <= start;
         collide_q   <= collide;
         // x^10 + x^7 + 1, nonzero seed keeps it out of the all-zero lockup
         lfsr        <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
         freeze      <= state_n != PLAY;
         spawn_grant <= '0;
         level       <= (lvl_div > 16'd7) ? 3'd7 : lvl_div[2:0];
         if (state == IDLE && start_rise) begin
            score <= '0;
            level <= '0;
            lives <= 3'(LIVES);
            gap   <= '0;
            ptr   <= '0;
         end
         if (state == PLAY) begin
            if (collide_rise) begin
               lives   <= lives - 3'd1;
               hit_cnt <= HW'(HIT_FRAMES - 1);
            end
            if (grant_ok) begin
               spawn_grant <= 4'b0001 << gnt_idx;
               // lfsr < 1024 < 2*X_RANGE, so one subtraction is a full modulo
               spawn_x     <= (lfsr >= 10'(X_RANGE)) ? lfsr - 10'(X_RANGE) : lfsr;
               spawn_speed <= 4'd2 + {1'b0, level};
               ptr         <= gnt_idx + 2'd1;
               gap         <= GW'(SPAWN_GAP - 1);
               if (score != 16'hFFFF) score <= score + 16'd1;
            end else if (gap != '0) gap <= gap - GW'(1);
         end
         if (state == HIT && hit_cnt != '0) hit_cnt <= hit_cnt - HW'(1);
      end
endmodule

// File: tb/tb_meteor_spawn_ctrl.sv
// tb_meteor_spawn_ctrl: directed and randomized checks of meteor_spawn_ctrl against a frame-level game model
module tb_meteor_spawn_ctrl;
   localparam int LIVES = 3, HIT_FRAMES = 60, SPAWN_GAP = 8, LEVEL_PTS = 16, X_RANGE = 556;

   logic        frame_clk = 1'b0;
   logic        Reset = 1'b0;
   logic        start = 1'b0;
   logic        collide = 1'b0;
   logic [3:0]  slot_req = '0;
   logic [9:0]  seed = 10'h155;
   logic [1:0]  game_state;
   logic        freeze;
   logic [3:0]  spawn_grant;
   logic [9:0]  spawn_x;
   logic [3:0]  spawn_speed;
   logic [15:0] score;
   logic [2:0]  lives;
   logic [2:0]  level;

   meteor_spawn_ctrl #(
      .LIVES(LIVES), .HIT_FRAMES(HIT_FRAMES), .SPAWN_GAP(SPAWN_GAP),
      .LEVEL_PTS(LEVEL_PTS), .X_RANGE(X_RANGE)
   ) dut (
      .frame_clk(frame_clk), .Reset(Reset), .start(start), .collide(collide),
      .slot_req(slot_req), .seed(seed), .game_state(game_state), .freeze(freeze),
      .spawn_grant(spawn_grant), .spawn_x(spawn_x), .spawn_speed(spawn_speed),
      .score(score), .lives(lives), .level(level)
   );

   always #5 frame_clk = ~frame_clk;

   int n_cmp = 0, n_bad = 0, cyc = 0;
   int m_st, m_lives, m_score, m_level, m_ptr, m_gap, m_hit, m_lfsr;
   int m_sq, m_cq, m_grant, m_x, m_speed, m_freeze;
   logic [3:0] gq[$];
   int gt[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic m_reset();
      m_st = 0; m_freeze = 1; m_grant = 0; m_x = 0; m_speed = 2;
      m_score = 0; m_lives = LIVES; m_level = 0; m_ptr = 0; m_gap = 0; m_hit = 0;
      m_lfsr = (seed == 0) ? 'h2A5 : int'(seed);
      m_sq = 0; m_cq = 0;
   endtask

   // one frame of game rules, all from the pre-edge values
   task automatic m_step();
      int sr, cr, nl, idx;
      sr = int'(start) & (m_sq ^ 1);
      cr = int'(collide) & (m_cq ^ 1);
      nl = m_score / LEVEL_PTS;
      if (nl > 7) nl = 7;
      m_grant = 0;
      case (m_st)
         0: if (sr != 0) begin
               m_st = 1; m_score = 0; nl = 0; m_lives = LIVES; m_gap = 0; m_ptr = 0;
            end
         1: begin
               if (cr != 0) begin
                  m_lives = m_lives - 1; m_hit = HIT_FRAMES - 1; m_st = 2;
                  if (m_gap > 0) m_gap = m_gap - 1;
               end else if (m_gap == 0 && slot_req != 0) begin
                  idx = -1;
                  for (int k = 0; k < 4; k++)
                     if (idx < 0 && slot_req[(m_ptr + k) % 4]) idx = (m_ptr + k) % 4;
                  m_grant = 1 << idx;
                  m_x = m_lfsr % X_RANGE;
                  m_speed = 2 + m_level;
                  m_ptr = (idx + 1) % 4;
                  m_gap = SPAWN_GAP - 1;
                  if (m_score < 65535) m_score = m_score + 1;
               end else if (m_gap > 0) m_gap = m_gap - 1;
            end
         2: if (m_hit == 0) m_st = (m_lives == 0) ? 3 : 1;
            else m_hit = m_hit - 1;
         default: if (sr != 0) m_st = 0;
      endcase
      m_level = nl;
      m_freeze = (m_st != 1) ? 1 : 0;
      m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1)) & 1023;
      m_sq = int'(start);
      m_cq = int'(collide);
   endtask

   task automatic cmp_all();
      chk("state", game_state, m_st);
      chk("freeze", freeze, m_freeze);
      chk("grant", spawn_grant, m_grant);
      chk("spawn_x", spawn_x, m_x);
      chk("speed", spawn_speed, m_speed);
      chk("score", score, m_score);
      chk("lives", lives, m_lives);
      chk("level", level, m_level);
   endtask

   task automatic tick();
      @(posedge frame_clk);
      if (Reset) m_reset();
      else m_step();
      cyc++;
      #1;
      cmp_all();
   endtask

   initial begin
      int n, g, s0;
      seed = 10'($urandom_range(1, 1023));
      #1 Reset = 1'b1;
      #1 m_reset();
      cmp_all();
      tick();
      Reset = 1'b0;
      repeat (2) tick();

      // start
      start = 1'b1;
      tick();
      chk("start_state", game_state, 1);
      chk("start_freeze", freeze, 0);
      chk("start_lives", lives, 3);
      chk("start_score", score, 0);
      start = 1'b0;

      // round robin with all slots requesting
      slot_req = 4'hF;
      repeat (40) begin
         tick();
         if (spawn_grant != 0) begin
            gq.push_back(spawn_grant);
            gt.push_back(cyc);
            chk("rr_x_range", 32'(spawn_x < 10'd556), 1);
         end
      end
      chk("rr_g0", gq[0], 4'b0001);
      chk("rr_g1", gq[1], 4'b0010);
      chk("rr_g2", gq[2], 4'b0100);
      chk("rr_g3", gq[3], 4'b1000);
      chk("rr_g4", gq[4], 4'b0001);
      for (int k = 0; k < 4; k++) chk("rr_spacing", gt[k+1] - gt[k], SPAWN_GAP);
      chk("rr_score", score, 5);

      // hit with collide held through the freeze
      collide = 1'b1;
      tick();
      chk("hit_state", game_state, 2);
      chk("hit_freeze", freeze, 1);
      chk("hit_lives", lives, 2);
      repeat (59) begin
         tick();
         chk("hit_no_grant", spawn_grant, 0);
      end
      chk("hit_still", game_state, 2);
      tick();
      chk("hit_resume", game_state, 1);
      repeat (5) tick();
      chk("held_collide_lives", lives, 2);

      // collide and request in the same frame
      collide = 1'b0;
      slot_req = 4'b0000;
      repeat (10) tick();
      slot_req = 4'b0100;
      collide = 1'b1;
      s0 = m_score;
      tick();
      chk("conf_grant", spawn_grant, 0);
      chk("conf_score", score, s0);
      chk("conf_state", game_state, 2);
      repeat (60) tick();
      chk("conf_resume", game_state, 1);
      slot_req = 4'hF;
      n = 0;
      while (spawn_grant == 0 && n < 20) begin
         tick();
         n++;
      end
      chk("conf_next_slot", spawn_grant, 4'b0100);

      // third hit leads to game over, then back through IDLE
      collide = 1'b0;
      tick();
      collide = 1'b1;
      tick();
      chk("last_lives", lives, 0);
      repeat (60) tick();
      chk("over_state", game_state, 3);
      collide = 1'b0;
      start = 1'b1;
      tick();
      chk("over_to_idle", game_state, 0);
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      chk("restart_state", game_state, 1);
      chk("restart_lives", lives, 3);
      chk("restart_score", score, 0);
      start = 1'b0;

      // level step after LEVEL_PTS grants
      slot_req = 4'hF;
      g = 0;
      n = 0;
      while (g < 17 && n < 400) begin
         tick();
         n++;
         if (spawn_grant != 0) begin
            g++;
            if (g == 17) chk("lvl_speed", spawn_speed, 3);
         end
      end
      chk("lvl_grants", g, 17);
      chk("lvl_level", level, 1);

      // asynchronous reset mid-PLAY with seed 0
      seed = 10'd0;
      Reset = 1'b1;
      #1 m_reset();
      cmp_all();
      chk("async_play_state", game_state, 0);
      tick();
      Reset = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      slot_req = 4'b0001;
      n = 0;
      while (spawn_grant == 0 && n < 20) begin
         tick();
         n++;
      end
      chk("seed0_grant", spawn_grant, 4'b0001);
      chk("seed0_x", spawn_x, m_x);

      // asynchronous reset mid-HIT
      collide = 1'b1;
      tick();
      repeat (5) tick();
      chk("mid_hit_state", game_state, 2);
      seed = 10'($urandom);
      Reset = 1'b1;
      #1 m_reset();
      cmp_all();
      chk("async_hit_freeze", freeze, 1);
      tick();
      Reset = 1'b0;
      collide = 1'b0;

      // randomized play
      repeat (3000) begin
         start = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 24) == 0) collide = ~collide;
         slot_req = 4'($urandom);
         if ($urandom_range(0, 599) == 0) begin
            seed = 10'($urandom);
            Reset = 1'b1;
         end else Reset = 1'b0;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
